mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline boundary, directly downstream of the data memory.
- Takes the combinational memory read word plus MEM-stage control and aligns/extends sub-word loads.
- Selects the write-back value and registers everything for the WB stage.
- Also flags misaligned loads and provides stall/flush bubble control for the hazard unit.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_AW, 5, register-file index width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- stall_i  in  1  hold the current MEM/WB contents.
- flush_i  in  1  insert a bubble.
- valid_i  in  1  the MEM-stage instruction is real (not a bubble).
- RegWrite_i  in  1  the instruction writes the register file.
- MemtoReg_i  in  1  1 = write-back value comes from memory, 0 = from ALU.
- MemRead_i  in  1  the instruction is a load.
- LoadType_i  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; others are treated as LW.
- addr_i  in  32  ALU result / memory address.
- read_data_i  in  32  word from data memory.
- rd_i  in  REG_AW  destination register index.
- valid_o  out  1  WB-stage instruction is valid.
- RegWrite_o  out  1  register-file write enable.
- rd_o  out  REG_AW  write-back register index.
- wb_data_o  out  32  write-back data.
- misaligned_o  out  1  load alignment fault for the registered instruction.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high; clock port clk, reset port rst_i.
- Reset: on a rising edge with rst_i=1, all outputs become 0, including valid_o, RegWrite_o, rd_o, wb_data_o and misaligned_o.
- Latency: exactly 1 cycle from MEM-stage inputs to registered outputs. All outputs are driven only from flops.
- Update priority per edge: rst_i > flush_i > stall_i > normal capture.
  - flush_i=1: valid_o=0, RegWrite_o=0, misaligned_o=0. rd_o and wb_data_o are cleared to 0. flush_i overrides a simultaneous stall_i.
  - stall_i=1 (no flush): every output register holds its value.
  - Normal capture: load all fields from the D-side logic below.
- Byte-lane extraction (little-endian; lane k = read_data_i[8k+7:8k], k = addr_i[1:0]):
  - LW: the full word.
  - LH/LHU: halfword at addr_i[1] (0 → bits 15:0, 1 → bits 31:16). LH sign-extends, LHU zero-extends.
  - LB/LBU: byte at lane addr_i[1:0]. LB sign-extends, LBU zero-extends.
- Write-back select: wb data = (MemtoReg_i & MemRead_i) ? extracted load : addr_i.
- Misalignment is evaluated only when MemRead_i & valid_i:
  - Misaligned cases: LW with addr_i[1:0]≠0; LH/LHU with addr_i[0]=1. Byte loads are never misaligned.
  - Misaligned load: misaligned_o=1, RegWrite_o=0, valid_o=1. wb_data_o still captures the extracted value for debug visibility.
- Bubble input (valid_i=0): captured as valid_o=0, RegWrite_o=0, misaligned_o=0.
- rd=0 guard: RegWrite_o is forced to 0 when rd_i=0.
- Reset mid-stall: reset wins and clears the stage. The first post-reset edge without stall captures normally.

Optional Feature:
- Macro: MEM_WB_PERF_CNT_EN.
- When defined, add output ports load_cnt_o [31:0] and misalign_cnt_o [31:0].
  - load_cnt_o increments on each capture edge with valid_i & MemRead_i & ~stall_i & ~flush_i.
  - misalign_cnt_o increments on such edges when the load is misaligned.
  - Both counters clear on rst_i, wrap modulo 2^32, and hold during stall.
- When not defined, neither port nor counter exists and the behaviour is otherwise identical.

Decomposition:
- Shared package (pipeline_pkg), holding:
  - LoadType encodings (LT_LW, LT_LH, LT_LHU, LT_LB, LT_LBU) and the 3-bit load_type_t typedef.
  - The DATA_W/REG_AW defaults.
  - A mem_wb_bus_t struct grouping valid/RegWrite/rd/wb_data/misaligned.
- One natural sub-module: load_align, purely combinational. It maps LoadType, addr[1:0] and the read word to the extended data plus the misaligned flag, and is reusable by a later cache path.
- The mem_wb_stage top holds the registers, priority logic and optional counters.

Test Plan:
- Reset: hold rst_i=1 for 2 edges with random inputs → all outputs 0. Release → the first capture matches the D-side.
- Sub-word loads with read_data_i=0x80FF7F01:
  - LB, addr 0x10 → wb_data_o=0x00000001.
  - LB, addr 0x13 → 0xFFFFFF80.
  - LBU, addr 0x12 → 0x000000FF.
  - LH, addr 0x12 → 0xFFFF80FF.
  - LHU, addr 0x10 → 0x00007F01.
  - Each case: RegWrite_o=1, latency 1.
- Misaligned: LW addr 0x22 → misaligned_o=1, RegWrite_o=0, valid_o=1. LH addr 0x21 → same. LB addr 0x21 → misaligned_o=0.
- Stall/flush:
  - Capture an ALU op with result 0x1234 to rd=5, then stall_i=1 for 3 cycles with changing inputs → outputs hold 0x1234/rd 5.
  - flush_i=1 together with stall_i=1 → valid_o=0, RegWrite_o=0 on that edge.
- ALU path and rd=0: MemtoReg_i=0, addr_i=0xDEADBEEF, rd=7 → wb_data_o=0xDEADBEEF. Same with rd=0 → RegWrite_o=0.
- MEM_WB_PERF_CNT_EN: 4 loads (1 misaligned), 1 stalled load, 1 flushed load → load_cnt_o=4, misalign_cnt_o=1. rst_i → both 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared MEM/WB types, load encodings and width defaults
package pipeline_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LH  = 3'b001,
    LT_LHU = 3'b010,
    LT_LB  = 3'b011,
    LT_LBU = 3'b100
  } load_type_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [REG_AW_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] wb_data;
    logic                  misaligned;
  } mem_wb_bus_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational sub-word load lane select, extension and alignment check
module load_align
  import pipeline_pkg::*;
(
  input  logic [2:0]            load_type,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_W_DEF-1:0] read_data,
  output logic [DATA_W_DEF-1:0] load_data,
  output logic                  misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword lanes (little-endian).
  always_comb begin
    byte_sel = read_data[7:0];
    case (addr_lo)
      2'd0:    byte_sel = read_data[7:0];
      2'd1:    byte_sel = read_data[15:8];
      2'd2:    byte_sel = read_data[23:16];
      default: byte_sel = read_data[31:24];
    endcase
    half_sel = addr_lo[1] ? read_data[31:16] : read_data[15:0];
  end

  // Extend the selected lane; unknown load types behave as word loads.
  always_comb begin
    load_data  = read_data;
    misaligned = 1'b0;
    case (load_type)
      LT_LH: begin
        load_data  = {{16{half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      LT_LHU: begin
        load_data  = {16'h0000, half_sel};
        misaligned = addr_lo[0];
      end
      LT_LB: begin
        load_data  = {{24{byte_sel[7]}}, byte_sel};
      end
      LT_LBU: begin
        load_data  = {24'h000000, byte_sel};
      end
      default: begin
        load_data  = read_data;
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load alignment; optional MEM_WB_PERF_CNT_EN counters
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic [2:0]        LoadType_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [REG_AW-1:0] rd_i,
`ifdef MEM_WB_PERF_CNT_EN
  output logic [31:0]       load_cnt_o,
  output logic [31:0]       misalign_cnt_o,
`endif
  output logic              valid_o,
  output logic              RegWrite_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              misaligned_o
);

  logic [DATA_W-1:0] load_data;
  logic              align_fault;
  logic              is_load;
  logic              load_mis;
  mem_wb_bus_t       d_bus;
  mem_wb_bus_t       q_bus;

  load_align u_load_align (
    .load_type  (LoadType_i),
    .addr_lo    (addr_i[1:0]),
    .read_data  (read_data_i),
    .load_data  (load_data),
    .misaligned (align_fault)
  );

  // D-side: build the next MEM/WB contents from the MEM-stage inputs.
  always_comb begin
    is_load           = valid_i & MemRead_i;
    load_mis          = is_load & align_fault;
    d_bus             = '0;
    d_bus.valid       = valid_i;
    d_bus.misaligned  = load_mis;
    // A faulting load still reaches WB (for the trap) but must not write.
    d_bus.reg_write   = valid_i & RegWrite_i & (rd_i != '0) & ~load_mis;
    d_bus.rd          = rd_i;
    d_bus.wb_data     = (MemtoReg_i & MemRead_i) ? load_data : addr_i;
  end

  // Pipeline register: reset > flush > stall > capture.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      q_bus <= '0;
    end else if (flush_i) begin
      q_bus <= '0;
    end else if (!stall_i) begin
      q_bus <= d_bus;
    end
  end

  assign valid_o      = q_bus.valid;
  assign RegWrite_o   = q_bus.reg_write;
  assign rd_o         = q_bus.rd;
  assign wb_data_o    = q_bus.wb_data;
  assign misaligned_o = q_bus.misaligned;

`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0] load_cnt;
  logic [31:0] misalign_cnt;

  // Count loads (and faulting loads) that actually enter WB.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      load_cnt     <= '0;
      misalign_cnt <= '0;
    end else if (!flush_i && !stall_i && is_load) begin
      load_cnt <= load_cnt + 32'd1;
      if (load_mis) begin
        misalign_cnt <= misalign_cnt + 32'd1;
      end
    end
  end

  assign load_cnt_o     = load_cnt;
  assign misalign_cnt_o = misalign_cnt;
`endif

endmodule
